serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1: bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in; used only when sub=0.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 selects A+B+cin; 1 selects A-B.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0; there is no overlap of operations.
REQ-018 Acceptance SHALL occur on an edge where in_valid=1 and in_ready=1; a, b, cin and sub are captured at that edge only.
REQ-019 On acceptance: A register <= a; B register <= (sub ? ~b : b); carry register <= (sub ? 1 : cin); digit counter <= 0; state -> RUN.
REQ-020 Each RUN edge SHALL add the low DIGIT bits of A and B plus the carry register, as full-adder ripple across DIGIT bits; update carry; shift the digit result into sum from the MSB end; shift A and B right by DIGIT; increment counter.
REQ-021 After N = WIDTH/DIGIT RUN edges, state -> DONE; out_valid SHALL rise exactly N edges after the accepting edge.
REQ-022 At completion, cout SHALL be the final carry and ovf SHALL be (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 In DONE, out_valid SHALL be 1 and sum/cout/ovf SHALL hold stable until an edge with out_ready=1, at which state -> IDLE and out_valid falls.
REQ-024 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-025 out_valid SHALL be 0 in IDLE and RUN; sum/cout/ovf are don't-care while out_valid=0 but SHALL not change in DONE.
REQ-026 A new operation MAY be accepted no earlier than the edge after the DONE->IDLE transition (back-to-back throughput one result per N+2 cycles).
REQ-027 Subtraction borrow convention: cout=1 means no borrow (a >= b unsigned).

Reset
REQ-028 On an edge with rst=1, state SHALL become IDLE regardless of current state, including mid-RUN; the operation in flight is discarded.
REQ-029 After reset: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, counter=0, carry register=0.
REQ-030 rst SHALL take priority over acceptance and over the out_ready handshake on the same edge.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-031 a=0x0F, b=0x01, cin=0, sub=0 -> out_valid 8 edges after accept; sum=0x10, cout=0, ovf=0.
REQ-032 a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-033 a=0x05, b=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout, ovf stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-035 rst=1 on the 3rd RUN edge -> next cycle in_ready=1, out_valid=0, sum=0; a subsequent operation completes correctly.
REQ-036 DIGIT=4: a=0x3C, b=0x0D, cin=0 -> out_valid 2 edges after accept, sum=0x49, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with a valid/ready handshake.
// Adds DIGIT bits per clock, LSB digit first, result shifted in from the top.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_dsum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sum_nx;
  logic             w_accept;
  logic             w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);

  // Ripple the low digit of A and B through DIGIT full adders.
  always_comb begin
    logic c;
    c      = r_carry;
    w_dsum = '0;
    w_cmsb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      w_cmsb    = c;
      w_dsum[i] = r_a[i] ^ r_b[i] ^ c;
      c = (r_a[i] & r_b[i]) | (c & (r_a[i] ^ r_b[i]));
    end
    w_cout = c;
  end

  // New digit enters the result at the MSB end.
  if (DIGIT == WIDTH) begin : g_full
    assign w_sum_nx = w_dsum;
  end else begin : g_part
    assign w_sum_nx = {w_dsum, r_sum[WIDTH-1:DIGIT]};
  end

  // Control FSM plus operand/result datapath; reset wins over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_nx;
          r_carry <= w_cout;
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout  <= w_cout;
            r_ovf   <= w_cmsb ^ w_cout;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: bit-serial (DIGIT=1)
// and nibble-serial (DIGIT=4) instances, hand-computed results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, s1;
  logic       ci1 = 1'b0, sb1 = 1'b0, co1, of1;

  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0, s4;
  logic       ci4 = 1'b0, sb4 = 1'b0, co4, of4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(ci1), .sub(sb1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1), .ovf(of1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(ci4), .sub(sb4),
    .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(co4), .ovf(of4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for result, check latency and value,
  // optionally leave it parked in DONE.
  task automatic do_op(input bit d4, input string tag,
                       input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vs,
                       input logic [7:0] es, input logic ec,
                       input logic eo, input bit release_it);
    int lat;
    int elat;
    elat = d4 ? 2 : 8;
    if (d4) begin
      a4 = va; b4 = vb; ci4 = vc; sb4 = vs; iv4 = 1'b1;
    end else begin
      a1 = va; b1 = vb; ci1 = vc; sb1 = vs; iv1 = 1'b1;
    end
    tick();
    iv1 = 1'b0; iv4 = 1'b0;
    lat = 0;
    while (!(d4 ? ov4 : ov1) && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".sum"}, d4 ? s4 : s1, es);
    chk({tag, ".cout"}, d4 ? co4 : co1, ec);
    chk({tag, ".ovf"}, d4 ? of4 : of1, eo);
    if (release_it) begin
      or1 = 1'b1; or4 = 1'b1;
      tick();
      or1 = 1'b0; or4 = 1'b0;
      chk({tag, ".vld_drop"}, d4 ? ov4 : ov1, 1'b0);
      chk({tag, ".rdy_back"}, d4 ? ir4 : ir1, 1'b1);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst.in_ready", ir1, 1'b1);
    chk("rst.out_valid", ov1, 1'b0);
    chk("rst.sum", s1, 8'h00);
    chk("rst.cout", co1, 1'b0);
    chk("rst.ovf", of1, 1'b0);
    // Reset must beat acceptance on the same edge.
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("rst_prio.in_ready", ir1, 1'b1);
    rst = 1'b0;

    do_op(0, "add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1);
    do_op(0, "add7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1);
    do_op(0, "addff01c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1);
    do_op(0, "sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1);
    do_op(0, "sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1);
    do_op(0, "sub3333", 8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1);
    do_op(0, "add8080", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

    // Park a result in DONE and poke it with in_valid.
    do_op(0, "hold", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      a1 = 8'hAA; b1 = 8'h55; iv1 = i[0];
      tick();
      chk("hold.valid", ov1, 1'b1);
      chk("hold.sum", s1, 8'h46);
      chk("hold.cout", co1, 1'b0);
      chk("hold.ovf", of1, 1'b0);
      chk("hold.in_ready", ir1, 1'b0);
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    chk("hold.release", ov1, 1'b0);
    chk("hold.idle", ir1, 1'b1);

    // Abort mid-RUN on the third RUN edge.
    a1 = 8'h11; b1 = 8'h22; ci1 = 1'b0; sb1 = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.in_ready", ir1, 1'b1);
    chk("abort.out_valid", ov1, 1'b0);
    chk("abort.sum", s1, 8'h00);
    do_op(0, "post_abort", 8'h3C, 8'h0D, 1'b0, 1'b0, 8'h49, 1'b0, 1'b0, 1);

    do_op(1, "d4_3c0d", 8'h3C, 8'h0D, 1'b0, 1'b0, 8'h49, 1'b0, 1'b0, 1);
    do_op(1, "d4_7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1);
    do_op(1, "d4_sub", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
